// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - DEPTH-entry FIFO of fetched instruction words feeding the control module
//
// Purpose: buffers fetched instruction words between memory fetch and control.
//   The head opcode is always presented; the full head word only while IQ_rd_en=1.
//   Supports a pop handshake, branch flush, occupancy and sticky overflow/underflow.
// Ports:
//   IQ_clk, IQ_rst            clock, synchronous active-high reset
//   IQ_in, IQ_wr_en           instruction word and push request
//   IQ_adv                    pop request (retire head)
//   IQ_flush                  discard all entries, clear flags
//   IQ_rd_en                  expose low field of head word on IQ_out
//   IQ_out, IQ_opcode         head word / head opcode, zero when empty
//   IQ_valid, IQ_full         non-empty / count == DEPTH
//   IQ_count                  occupancy
//   IQ_ovf, IQ_udf            sticky dropped-push / pop-while-empty
module instruction_queue #(
    parameter int WIDTH = 16,
    parameter int OPC_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                       IQ_clk,
    input  logic                       IQ_rst,
    input  logic [WIDTH-1:0]           IQ_in,
    input  logic                       IQ_wr_en,
    input  logic                       IQ_adv,
    input  logic                       IQ_flush,
    input  logic                       IQ_rd_en,
    output logic [WIDTH-1:0]           IQ_out,
    output logic [OPC_W-1:0]           IQ_opcode,
    output logic                       IQ_valid,
    output logic                       IQ_full,
    output logic [$clog2(DEPTH+1)-1:0] IQ_count,
    output logic                       IQ_ovf,
    output logic                       IQ_udf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rp;
    logic [PW-1:0]    wp;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;
    logic             push;
    logic             pop;
    logic             is_full;
    logic             is_empty;
    logic [WIDTH-1:0] head;

    assign is_full  = (count == CW'(DEPTH));
    assign is_empty = (count == '0);

    // A full queue can still accept a push when the head retires in the same cycle.
    assign pop  = IQ_adv & ~is_empty;
    assign push = IQ_wr_en & (~is_full | pop);

    always_ff @(posedge IQ_clk) begin
        if (IQ_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rp    <= '0;
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (IQ_flush) begin
            // Memory is left as-is; valid=0 gates every output while empty.
            rp    <= '0;
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (push) begin
                mem[wp] <= IQ_in;
                wp      <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            if (IQ_wr_en && !push) begin
                ovf <= 1'b1;
            end
            if (IQ_adv && is_empty) begin
                udf <= 1'b1;
            end
        end
    end

    assign head      = mem[rp];
    assign IQ_valid  = ~is_empty;
    assign IQ_full   = is_full;
    assign IQ_count  = count;
    assign IQ_ovf    = ovf;
    assign IQ_udf    = udf;
    assign IQ_opcode = IQ_valid ? head[WIDTH-1 -: OPC_W] : '0;

    // The low field only exists when the opcode does not span the whole word.
    generate
        if (OPC_W < WIDTH) begin : g_low_field
            assign IQ_out = {IQ_opcode,
                             (IQ_valid & IQ_rd_en) ? head[WIDTH-OPC_W-1:0] : {(WIDTH-OPC_W){1'b0}}};
        end else begin : g_opcode_only
            assign IQ_out = IQ_opcode;
        end
    endgenerate

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - self-checking bench for instruction_queue at two parameter sets
module tb_instruction_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DUT0: WIDTH=16, OPC_W=8, DEPTH=4
    logic        rst0 = 1'b1, wr0 = 1'b0, adv0 = 1'b0, flush0 = 1'b0, rd0 = 1'b0;
    logic [15:0] in0 = '0;
    logic [15:0] out0;
    logic [7:0]  opc0;
    logic        valid0, full0, ovf0, udf0;
    logic [2:0]  cnt0;

    // DUT1: WIDTH=24, OPC_W=6, DEPTH=8
    logic        rst1 = 1'b1, wr1 = 1'b0, adv1 = 1'b0, flush1 = 1'b0, rd1 = 1'b0;
    logic [23:0] in1 = '0;
    logic [23:0] out1;
    logic [5:0]  opc1;
    logic        valid1, full1, ovf1, udf1;
    logic [3:0]  cnt1;

    instruction_queue #(.WIDTH(16), .OPC_W(8), .DEPTH(4)) dut0 (
        .IQ_clk(clk), .IQ_rst(rst0), .IQ_in(in0), .IQ_wr_en(wr0), .IQ_adv(adv0),
        .IQ_flush(flush0), .IQ_rd_en(rd0), .IQ_out(out0), .IQ_opcode(opc0),
        .IQ_valid(valid0), .IQ_full(full0), .IQ_count(cnt0), .IQ_ovf(ovf0), .IQ_udf(udf0)
    );

    instruction_queue #(.WIDTH(24), .OPC_W(6), .DEPTH(8)) dut1 (
        .IQ_clk(clk), .IQ_rst(rst1), .IQ_in(in1), .IQ_wr_en(wr1), .IQ_adv(adv1),
        .IQ_flush(flush1), .IQ_rd_en(rd1), .IQ_out(out1), .IQ_opcode(opc1),
        .IQ_valid(valid1), .IQ_full(full1), .IQ_count(cnt1), .IQ_ovf(ovf1), .IQ_udf(udf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural models: a plain queue of words plus two sticky bits per DUT.
    logic [15:0] mq0[$];
    logic [23:0] mq1[$];
    bit m_ovf0, m_udf0, m_ovf1, m_udf1;
    bit armed0 = 0, armed1 = 0;
    bit mpop0, mpush0, mpop1, mpush1;

    always @(posedge clk) begin
        if (rst0 || flush0) begin
            mq0.delete();
            m_ovf0 = 0;
            m_udf0 = 0;
        end else begin
            mpop0  = adv0 && mq0.size() > 0;
            mpush0 = wr0 && (mq0.size() < 4 || mpop0);
            if (adv0 && mq0.size() == 0) m_udf0 = 1;
            if (wr0 && !mpush0) m_ovf0 = 1;
            if (mpop0) void'(mq0.pop_front());
            if (mpush0) mq0.push_back(in0);
        end
        if (rst1 || flush1) begin
            mq1.delete();
            m_ovf1 = 0;
            m_udf1 = 0;
        end else begin
            mpop1  = adv1 && mq1.size() > 0;
            mpush1 = wr1 && (mq1.size() < 8 || mpop1);
            if (adv1 && mq1.size() == 0) m_udf1 = 1;
            if (wr1 && !mpush1) m_ovf1 = 1;
            if (mpop1) void'(mq1.pop_front());
            if (mpush1) mq1.push_back(in1);
        end
    end

    // Compare process: every falling edge once each DUT has seen a reset.
    always @(negedge clk) begin
        logic [15:0] h0;
        logic [23:0] h1;
        if (armed0) begin
            h0 = (mq0.size() > 0) ? mq0[0] : 16'h0;
            check("d0_opcode", 32'(opc0), 32'(h0[15:8]));
            check("d0_out", 32'(out0), 32'({h0[15:8], rd0 ? h0[7:0] : 8'h00}));
            check("d0_valid", 32'(valid0), 32'(mq0.size() > 0));
            check("d0_full", 32'(full0), 32'(mq0.size() == 4));
            check("d0_count", 32'(cnt0), 32'(mq0.size()));
            check("d0_ovf", 32'(ovf0), 32'(m_ovf0));
            check("d0_udf", 32'(udf0), 32'(m_udf0));
        end
        if (armed1) begin
            h1 = (mq1.size() > 0) ? mq1[0] : 24'h0;
            check("d1_opcode", 32'(opc1), 32'(h1[23:18]));
            check("d1_out", 32'(out1), 32'({h1[23:18], rd1 ? h1[17:0] : 18'h0}));
            check("d1_valid", 32'(valid1), 32'(mq1.size() > 0));
            check("d1_full", 32'(full1), 32'(mq1.size() == 8));
            check("d1_count", 32'(cnt1), 32'(mq1.size()));
            check("d1_ovf", 32'(ovf1), 32'(m_ovf1));
            check("d1_udf", 32'(udf1), 32'(m_udf1));
        end
    end

    task automatic step0(input logic w, input logic [15:0] d, input logic a, input logic f);
        wr0 = w; in0 = d; adv0 = a; flush0 = f;
        @(posedge clk); #1;
        wr0 = 0; adv0 = 0; flush0 = 0; rst0 = 0;
    endtask

    task automatic step1(input logic w, input logic [23:0] d, input logic a, input logic f);
        wr1 = w; in1 = d; adv1 = a; flush1 = f;
        @(posedge clk); #1;
        wr1 = 0; adv1 = 0; flush1 = 0; rst1 = 0;
    endtask

    initial begin
        // Reset both DUTs.
        @(posedge clk); #1;
        @(posedge clk); #1;
        armed0 = 1; armed1 = 1;
        rst0 = 0; rst1 = 0;
        @(negedge clk);
        check("rst_out", 32'(out0), 32'h0);
        check("rst_count", 32'(cnt0), 32'h0);
        check("rst_valid", 32'(valid0), 32'h0);

        // Single push A1B2.
        step0(1, 16'hA1B2, 0, 0);
        @(negedge clk);
        check("a1_opcode", 32'(opc0), 32'hA1);
        check("a1_out_rd0", 32'(out0), 32'hA100);
        check("a1_count", 32'(cnt0), 32'h1);
        rd0 = 1; #1;
        check("a1_out_rd1", 32'(out0), 32'hA1B2);
        step0(0, 0, 1, 0);

        // Fill, overflow, drain in order.
        for (int i = 0; i < 4; i++) step0(1, 16'h1001 + 16'(i), 0, 0);
        @(negedge clk);
        check("fill_full", 32'(full0), 32'h1);
        check("fill_count", 32'(cnt0), 32'h4);
        step0(1, 16'h1005, 0, 0);
        @(negedge clk);
        check("ovf_set", 32'(ovf0), 32'h1);
        check("ovf_count", 32'(cnt0), 32'h4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_head", 32'(out0), 32'h1001 + i);
            step0(0, 0, 1, 0);
        end
        @(negedge clk);
        check("drain_valid", 32'(valid0), 32'h0);
        check("drain_out", 32'(out0), 32'h0);

        // Clear ovf, fill, then six cycles of concurrent push/pop across the wrap.
        step0(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step0(1, 16'h2001 + 16'(i), 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wrap_head", 32'(out0), 32'h2001 + i);
            step0(1, 16'h2005 + 16'(i), 1, 0);
        end
        @(negedge clk);
        check("wrap_count", 32'(cnt0), 32'h4);
        check("wrap_ovf", 32'(ovf0), 32'h0);
        check("wrap_head_end", 32'(out0), 32'h2007);

        // Underflow, then flush beating a same-cycle push.
        step0(0, 0, 0, 1);
        step0(0, 0, 1, 0);
        @(negedge clk);
        check("udf_set", 32'(udf0), 32'h1);
        check("udf_count", 32'(cnt0), 32'h0);
        step0(1, 16'h2233, 0, 1);
        @(negedge clk);
        check("flush_valid", 32'(valid0), 32'h0);
        check("flush_udf", 32'(udf0), 32'h0);
        check("flush_out", 32'(out0), 32'h0);

        // Reset overriding push and pop with three entries held.
        for (int i = 0; i < 3; i++) step0(1, 16'h3001 + 16'(i), 0, 0);
        rst0 = 1;
        step0(1, 16'h4444, 1, 0);
        @(negedge clk);
        check("rst_ovr_count", 32'(cnt0), 32'h0);
        check("rst_ovr_out", 32'(out0), 32'h0);
        step0(1, 16'hBEEF, 0, 0);
        @(negedge clk);
        check("beef_out", 32'(out0), 32'hBEEF);
        check("beef_count", 32'(cnt0), 32'h1);

        // Second parameter set.
        step1(1, 24'hFC1234, 0, 0);
        @(negedge clk);
        check("w24_opcode", 32'(opc1), 32'h3F);
        check("w24_out_rd0", 32'(out1), 32'hFC0000);
        step1(0, 0, 1, 0);
        rd1 = 1;
        for (int i = 0; i < 8; i++) step1(1, 24'h100001 + 24'(i), 0, 0);
        @(negedge clk);
        check("w24_full", 32'(full1), 32'h1);
        check("w24_count", 32'(cnt1), 32'h8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("w24_wrap_head", 32'(out1), 32'h100001 + i);
            step1(1, 24'h100009 + 24'(i), 1, 0);
        end
        @(negedge clk);
        check("w24_wrap_ovf", 32'(ovf1), 32'h0);
        step1(1, 24'h777777, 0, 0);
        @(negedge clk);
        check("w24_ovf", 32'(ovf1), 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("w24_drain", 32'(out1), 32'h10000B + i);
            step1(0, 0, 1, 0);
        end
        @(negedge clk);
        check("w24_empty", 32'(valid1), 32'h0);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
